// File: rtl/alu_mdu_if.sv
// Handshake and operand/result bundle between the EX stage and the alu_mdu execute unit.
interface alu_mdu_if #(
  parameter int unsigned d_width = 32,
  parameter int unsigned op      = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [op-1:0]      operator;
  logic [d_width-1:0] a;
  logic [d_width-1:0] b;
  logic               out_valid;
  logic               out_ready;
  logic [d_width-1:0] c;
  logic               zero;

  modport master (
    output in_valid, operator, a, b, out_ready,
    input  in_ready, out_valid, c, zero
  );

  modport slave (
    input  in_valid, operator, a, b, out_ready,
    output in_ready, out_valid, c, zero
  );
endinterface

// File: rtl/alu_mdu.sv
// RV32IM execute unit: single-cycle ALU ops plus a bit-serial shift-add multiplier and
// restoring divider working on operand magnitudes, all results registered with a zero flag.
module alu_mdu #(
  parameter int unsigned d_width = 32,
  parameter int unsigned op      = 5
) (
  input logic      clk,
  input logic      rst_n,
  alu_mdu_if.slave bus
);

  localparam int unsigned ShW  = $clog2(d_width);
  localparam int unsigned CntW = $clog2(d_width + 1);

  localparam logic [op-1:0] OpAdd  = op'(0);
  localparam logic [op-1:0] OpSub  = op'(1);
  localparam logic [op-1:0] OpSll  = op'(2);
  localparam logic [op-1:0] OpSlt  = op'(3);
  localparam logic [op-1:0] OpSltu = op'(4);
  localparam logic [op-1:0] OpXor  = op'(5);
  localparam logic [op-1:0] OpSrl  = op'(6);
  localparam logic [op-1:0] OpSra  = op'(7);
  localparam logic [op-1:0] OpOr   = op'(8);
  localparam logic [op-1:0] OpAnd  = op'(9);
  localparam logic [op-1:0] OpMul  = op'(10);
  localparam logic [op-1:0] OpMulh = op'(11);
  localparam logic [op-1:0] OpMulu = op'(12);
  localparam logic [op-1:0] OpDiv  = op'(13);
  localparam logic [op-1:0] OpDivu = op'(14);
  localparam logic [op-1:0] OpRem  = op'(15);
  localparam logic [op-1:0] OpRemu = op'(16);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [d_width-1:0] c_q, c_d;
  logic               zero_q, zero_d;
  logic [op-1:0]      op_q, op_d;
  logic [d_width-1:0] hi_q, hi_d;
  logic [d_width-1:0] lo_q, lo_d;
  logic [d_width-1:0] opnd_q, opnd_d;
  logic [d_width-1:0] a_q, a_d;
  logic               neg_q, neg_d;
  logic               nega_q, nega_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               is_mdu;
  logic               signed_op;
  logic               a_sgn, b_sgn;
  logic [ShW-1:0]     shamt;
  logic [d_width-1:0] simple_res;

  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign bus.out_valid = (state_q == StDone);
  assign bus.c         = c_q;
  assign bus.zero      = zero_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign is_mdu    = (bus.operator >= OpMul) && (bus.operator <= OpRemu);
  assign signed_op = (bus.operator == OpMul) || (bus.operator == OpMulh) ||
                     (bus.operator == OpDiv) || (bus.operator == OpRem);
  assign a_sgn     = signed_op && bus.a[d_width-1];
  assign b_sgn     = signed_op && bus.b[d_width-1];
  assign shamt     = bus.b[ShW-1:0];

  always_comb begin
    simple_res = '0;
    case (bus.operator)
      OpAdd:   simple_res = bus.a + bus.b;
      OpSub:   simple_res = bus.a - bus.b;
      OpSll:   simple_res = bus.a << shamt;
      OpSlt:   simple_res = {{(d_width-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OpSltu:  simple_res = {{(d_width-1){1'b0}}, bus.a < bus.b};
      OpXor:   simple_res = bus.a ^ bus.b;
      OpSrl:   simple_res = bus.a >> shamt;
      OpSra:   simple_res = $signed(bus.a) >>> shamt;
      OpOr:    simple_res = bus.a | bus.b;
      OpAnd:   simple_res = bus.a & bus.b;
      default: simple_res = '0;
    endcase
  end

  // One iteration of either datapath; hi holds product-high / partial remainder,
  // lo holds multiplier / dividend being shifted into the quotient.
  logic [d_width:0]     mul_sum, div_shift, div_diff;
  logic                 div_ok;
  logic                 is_div_q;
  logic [d_width-1:0]   iter_hi, iter_lo;
  logic [2*d_width-1:0] prod, prod_s;
  logic [d_width-1:0]   quo_s, rem_s, final_res;

  assign is_div_q = (op_q >= OpDiv);

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[d_width-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[d_width];
    if (is_div_q) begin
      iter_hi = div_ok ? div_diff[d_width-1:0] : div_shift[d_width-1:0];
      iter_lo = {lo_q[d_width-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[d_width:1];
      iter_lo = {mul_sum[0], lo_q[d_width-1:1]};
    end
  end

  // Sign correction and divide special cases, applied on the last iteration.
  always_comb begin
    prod      = {iter_hi, iter_lo};
    prod_s    = neg_q ? -prod : prod;
    quo_s     = neg_q ? -iter_lo : iter_lo;
    rem_s     = nega_q ? -iter_hi : iter_hi;
    final_res = '0;
    case (op_q)
      OpMul:          final_res = prod_s[d_width-1:0];
      OpMulh, OpMulu: final_res = prod_s[2*d_width-1:d_width];
      OpDiv, OpDivu:  final_res = dz_q ? '1 : (ovf_q ? a_q : quo_s);
      OpRem, OpRemu:  final_res = dz_q ? a_q : (ovf_q ? '0 : rem_s);
      default:        final_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    zero_d  = zero_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    neg_d   = neg_q;
    nega_d  = nega_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      StBusy: begin
        hi_d = iter_hi;
        lo_d = iter_lo;
        if (cnt_q == CntW'(1)) begin
          c_d     = final_res;
          zero_d  = (final_res == '0);
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (is_mdu) begin
            op_d    = bus.operator;
            hi_d    = '0;
            lo_d    = a_sgn ? -bus.a : bus.a;
            opnd_d  = b_sgn ? -bus.b : bus.b;
            a_d     = bus.a;
            neg_d   = a_sgn ^ b_sgn;
            nega_d  = a_sgn;
            dz_d    = (bus.b == '0);
            ovf_d   = signed_op && (bus.a == {1'b1, {(d_width-1){1'b0}}}) && (bus.b == '1);
            cnt_d   = CntW'(d_width);
            state_d = StBusy;
          end else begin
            c_d     = simple_res;
            zero_d  = (simple_res == '0);
            state_d = StDone;
          end
        end else if (state_q == StDone && bus.out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      c_q     <= '0;
      zero_q  <= 1'b0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      nega_q  <= nega_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu against a plain-arithmetic reference model.
module tb_alu_mdu;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mdu_if #(.d_width(W), .op(5)) bus ();

  alu_mdu #(.d_width(W), .op(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] opc, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (opc)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> sh;
      5'd7:  return 32'(sa >>> sh);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return 32'(sa * sb);
      5'd11: begin p = 64'(sa * sb); return p[63:32]; end
      5'd12: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd13: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      5'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd15: return (b == 0) ? a : 32'(sa % sb);
      5'd16: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] opc);
    return (opc >= 10 && opc <= 16) ? W + 1 : 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from idle, scramble inputs after acceptance, then check latency and result.
  task automatic run_op(input string tag, input logic [4:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.operator  = opc;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.operator = 5'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready) check({tag, "/busy_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat(opc)));
    check({tag, "/c"}, bus.c, exp);
    check({tag, "/zero"}, 32'(bus.zero), 32'(exp == 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops[4];
    logic [31:0] as[4], bs[4];
    logic [31:0] ra, rb;
    logic [4:0]  ro;
    int          lat;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.operator  = '0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (2) @(negedge clk);
    check("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst/c", bus.c, 32'd0);
    check("rst/zero", 32'(bus.zero), 32'd0);
    check("rst/in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    run_op("add", 5'd0, 32'd5, 32'd7, 32'd12);
    run_op("sub", 5'd1, 32'd7, 32'd7, 32'd0);
    run_op("sra", 5'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
    run_op("srl", 5'd6, 32'h8000_0000, 32'h24, 32'h0800_0000);
    run_op("slt", 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_op("sltu", 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_op("mulh", 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    run_op("mulhu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mul", 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run_op("divu0", 5'd14, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_op("remu0", 5'd16, 32'd7, 32'd0, 32'd7);
    run_op("div_ovf", 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("div_neg", 5'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_neg", 5'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("illegal", 5'd23, 32'd3, 32'd4, 32'd0);

    // Backpressure: result held with out_ready low, then released alongside a new add.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.operator  = 5'd13;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 100 && !bus.out_valid) begin
      @(negedge clk);
      lat++;
    end
    check("bp/latency", 32'(lat), W + 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp/out_valid", 32'(bus.out_valid), 32'd1);
      check("bp/c", bus.c, 32'd14);
      check("bp/in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.operator  = 5'd0;
    bus.a         = 32'd3;
    bus.b         = 32'd4;
    #1 check("bp/in_ready_release", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp/add_valid", 32'(bus.out_valid), 32'd1);
    check("bp/add_c", bus.c, 32'd7);

    // Back-to-back simple ops, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      ops[i] = 5'($urandom_range(0, 9));
      as[i]  = pick_operand();
      bs[i]  = pick_operand();
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.operator = ops[0];
    bus.a        = as[0];
    bus.b        = bs[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        bus.operator = ops[i+1];
        bus.a        = as[i+1];
        bus.b        = bs[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b/out_valid", 32'(bus.out_valid), 32'd1);
      check("b2b/c", bus.c, model(ops[i], as[i], bs[i]));
    end

    // Reset in cycle 10 of a divu aborts it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.operator = 5'd14;
    bus.a        = 32'd1000;
    bus.b        = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstbusy/out_valid", 32'(bus.out_valid), 32'd0);
    check("rstbusy/c", bus.c, 32'd0);
    check("rstbusy/in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.out_valid) check("rstbusy/no_result", 32'(bus.out_valid), 32'd0);
    end
    check("rstbusy/c_after", bus.c, 32'd0);
    run_op("add_after_rst", 5'd0, 32'd20, 32'd22, 32'd42);

    // Randomised ops against the reference model.
    for (int n = 0; n < 200; n++) begin
      ro = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(10, 16)) : 5'($urandom_range(0, 31));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, model(ro, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised RV32IM-capable execute unit for the core. It combines the single-cycle integer ALU operations with an iterative multiplier/divider behind a valid/ready handshake. The EX stage uses it: it issues one operation at a time and stalls on `in_ready`/`out_valid`. Every result is registered and comes with a `zero` flag for branch resolution.

## Interface
- `d_width`, 32: operand/result width; even, ≥ 8.
- `op`, 5: operator code width; fixed at 5 for the encoding below.
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `in_valid`  input  1  operation present on `operator`/`a`/`b`.
- `in_ready`  output  1  unit can accept; combinational.
- `operator`  input  op  operation code.
- `a`, `b`  input  d_width  operands.
- `out_valid`  output  1  `c`/`zero` hold a result.
- `out_ready`  input  1  consumer takes the result.
- `c`  output  d_width  result, registered.
- `zero`  output  1  high iff `c == 0`, registered with `c`.

## Operation
- Opcode map, simple class:
  - 0 add, 1 sub, 2 sll, 3 slt (signed), 4 sltu, 5 xor.
  - 6 srl, 7 sra (true arithmetic, sign-filled), 8 or, 9 and.
- Opcode map, iterative class:
  - 10 mul (low d_width bits of product), 11 mulh (signed×signed, high half), 12 mulhu (unsigned×unsigned, high half).
  - 13 div (signed), 14 divu, 15 rem (signed), 16 remu.
- Codes 17–31 are illegal. They take the simple class and return `c = 0`, `zero = 1`.
- Shift amount: `b[$clog2(d_width)-1:0]`. Upper bits of `b` are ignored.
- slt/sltu: result is 1 or 0, zero-extended to d_width.
- add/sub/mul wrap modulo 2^d_width.
- Divide by zero: div/divu give all-ones; rem/remu give `a`.
- Signed overflow (a = −2^(d_width−1), b = −1): div gives `a`; rem gives 0.
- Signed div/rem: the quotient rounds toward zero, and the remainder takes the sign of `a`.
- Mul/div datapath:
  - Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
  - Sign correction and special-case overrides are applied on the final iteration.
- Operands are captured at acceptance. Later changes on `a`/`b`/`operator` do not affect the operation in flight.
- States and transitions:
  - IDLE: `in_ready = 1`. On acceptance, a simple op moves to DONE with the result registered. A mul/div op moves to BUSY with counter = d_width.
  - BUSY: the counter decrements each cycle, with one iteration per cycle. When the counter reaches 1, the edge writes the final result and moves to DONE.
  - DONE: `out_valid = 1`; `c`/`zero` are stable.
    - `out_ready = 1` completes the result.
    - `in_ready = out_ready`, so a new op can be accepted in the same cycle (back-to-back).
    - With no new op, the unit returns to IDLE.
    - `out_ready = 0` holds the DONE state and its outputs indefinitely.
- `zero` is computed from the final result of every class, including the special cases.

## Timing
- Acceptance edge: the rising edge with `in_valid && in_ready`. Call it E0; the cycle after E0 is cycle 1.
- Simple/illegal latency: `out_valid` is high in cycle 1.
- Mul/div latency: BUSY in cycles 1..d_width, and `out_valid` is high in cycle d_width+1.
  - The latency is fixed, including divide-by-zero and overflow.
- Back-to-back simple ops with `out_ready` held high give one result per cycle.
- `in_ready` is 0 throughout BUSY. It is 0 in DONE while `out_ready = 0`.
- Reset values: state IDLE, `out_valid` 0, `c` 0, `zero` 0, counter 0. `in_ready` reads 1 while in reset.
- Reset asserted mid-BUSY or in DONE aborts the operation. No result is produced and the pending result is discarded.
- `out_valid` is never high while BUSY.

## Test plan
- Reset, then add: a=5, b=7 → `out_valid` in cycle 1, `c`=12, `zero`=0. Then sub 7−7 → `c`=0, `zero`=1.
- Shifts and compares:
  - sra a=0x80000000, b=0x24 (shift 4) → 0xF8000000.
  - srl with the same inputs → 0x08000000.
  - slt a=0xFFFFFFFF, b=1 → 1.
  - sltu with the same inputs → 0.
- Multiply:
  - mulh a=0xFFFFFFFF, b=0xFFFFFFFF → 0, with `out_valid` first high in cycle 33.
  - mulhu with the same inputs → 0xFFFFFFFE.
  - mul with the same inputs → 1.
- Divide specials:
  - divu 7/0 → 0xFFFFFFFF; remu 7/0 → 7.
  - div 0x80000000/0xFFFFFFFF → 0x80000000; rem with the same inputs → 0 (`zero`=1).
  - div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after a div completes → `c` stable and `in_ready`=0 throughout.
  - Then `out_ready`=1 with a new add presented → the add is accepted that edge, and its result appears next cycle.
- Assert `rst_n`=0 in cycle 10 of a divu → `out_valid` stays 0 and `c`=0. After release, the next add completes normally in 1 cycle.
